// File: rtl/object_spawner.sv
// Object spawner: paces new collectable/hazard objects by vsync frames and
// offers each packed 26-bit object to the game logic over valid/ready.
module object_spawner #(
  parameter int              SCREEN_WIDTH  = 1024,
  parameter int              OBJ_HEIGHT    = 20,
  parameter int              MIN_GAP       = 30,
  parameter int              GAP_RAND_BITS = 5,
  parameter int              JITTER_EN     = 1,
  parameter int              V_MIN         = 32,
  parameter int              V_MAX         = 700,
  parameter logic [15:0]     LFSR_SEED     = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vsync,
  input  logic [9:0]  wave_height,
  input  logic        wave_ready,
  input  logic [3:0]  speed,
  output logic        spawn_valid,
  input  logic        spawn_ready,
  output logic [25:0] spawn_obj,
  output logic [7:0]  spawn_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BUILD = 2'd2,
    OFFER = 2'd3
  } state_t;

  localparam logic [15:0]        LFSR_TAPS = 16'hB400;
  localparam logic [15:0]        RAND_MASK = 16'((32'd1 << GAP_RAND_BITS) - 32'd1);
  localparam logic [10:0]        HPOS      = 11'(SCREEN_WIDTH);
  localparam logic signed [11:0] OBJ_H_S   = 12'(OBJ_HEIGHT);
  localparam logic signed [11:0] V_MIN_S   = 12'(V_MIN);
  localparam logic signed [11:0] V_MAX_S   = 12'(V_MAX);

  state_t      state;
  logic [15:0] lfsr;
  logic [9:0]  height;
  logic [8:0]  gap;
  logic        vsync_prev;
  logic        armed;
  logic        vsync_pulse;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // MIN_GAP >= 1 keeps the reload value nonzero.
  function automatic logic [8:0] gap_value(input logic [15:0] v);
    gap_value = 9'(MIN_GAP) + 9'(v & RAND_MASK);
  endfunction

  function automatic logic [9:0] calc_vpos(input logic [9:0] h, input logic [15:0] v);
    logic signed [11:0] jit;
    logic signed [11:0] sum;
    if (JITTER_EN != 0) begin
      jit = $signed({6'd0, v[9:6], 2'b00}) - 12'sd32;
    end else begin
      jit = 12'sd0;
    end
    sum = $signed({2'b00, h}) - OBJ_H_S + jit;
    if (sum < V_MIN_S) begin
      calc_vpos = V_MIN_S[9:0];
    end else if (sum > V_MAX_S) begin
      calc_vpos = V_MAX_S[9:0];
    end else begin
      calc_vpos = sum[9:0];
    end
  endfunction

  // armed masks the first sample so a vsync already high at reset release is not an edge.
  assign vsync_pulse = vsync & ~vsync_prev & armed;

  // vsync edge history, free-running LFSR and wave height latch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_prev <= 1'b0;
      armed      <= 1'b0;
      lfsr       <= LFSR_SEED;
      height     <= 10'd384;
    end else begin
      vsync_prev <= vsync;
      armed      <= 1'b1;
      if (enable) begin
        lfsr <= lfsr_step(lfsr);
      end
      if (wave_ready) begin
        height <= wave_height;
      end
    end
  end

  // spawn sequencer with registered handshake outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gap         <= 9'd0;
      spawn_valid <= 1'b0;
      spawn_obj   <= 26'd0;
      spawn_count <= 8'd0;
    end else begin
      if (spawn_valid && spawn_ready) begin
        spawn_count <= spawn_count + 8'd1;
      end
      if (!enable) begin
        state       <= IDLE;
        spawn_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            gap   <= gap_value(lfsr);
            state <= WAIT;
          end
          WAIT: begin
            if (vsync_pulse && (speed != 4'd0)) begin
              if (gap <= 9'd1) begin
                state <= BUILD;
              end else begin
                gap <= gap - 9'd1;
              end
            end
          end
          BUILD: begin
            spawn_obj   <= {lfsr[2:0],
                            (lfsr[4:3] == 2'b11) ? 2'b01 : 2'b00,
                            HPOS,
                            calc_vpos(height, lfsr)};
            spawn_valid <= 1'b1;
            state       <= OFFER;
          end
          OFFER: begin
            if (spawn_ready) begin
              spawn_valid <= 1'b0;
              gap         <= gap_value(lfsr);
              state       <= WAIT;
            end
          end
          default: begin
            spawn_valid <= 1'b0;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
